// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and stage indices for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int STAGES_DEF = 6;

    typedef logic [STAGES_DEF-1:0] stall_vec_t;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Flush stretch counter width; FLUSH_CYCLES is limited to 1..15
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic {
        FL_IDLE,
        FL_FLUSH
    } flush_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - consecutive-stall counter with sticky timeout flag
module stall_watchdog #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            clr,
    output logic [$clog2(WDOG_LIMIT+1)-1:0] stall_cnt,
    output logic                            wdog
);

    localparam int CNT_W = $clog2(WDOG_LIMIT+1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);

    logic             counting;
    logic [CNT_W-1:0] cnt_next;
    logic             reach;

    assign counting = stall && !flush;
    assign cnt_next = (stall_cnt == LIMIT) ? LIMIT : stall_cnt + 1'b1;
    // Set only on the transition into saturation, not while parked there
    assign reach    = counting && (stall_cnt != LIMIT) && (cnt_next == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!counting) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= 1'b0;
        end else if (reach) begin
            wdog <= 1'b1;
        end else if (clr) begin
            wdog <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller with redirect hold and stall watchdog
// Optional per-stage stall counters enabled by PIPE_STALL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int STAGES       = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024,
    parameter int ADDR_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [STAGES-1:0]               stall_req_i,
    input  logic                            except_flush_i,
    input  logic [ADDR_W-1:0]               except_pc_i,
    input  logic                            redirect_ready_i,
    input  logic                            wdog_clr_i,
    output logic [STAGES-1:0]               stall_o,
    output logic                            flush_o,
    output logic                            redirect_valid_o,
    output logic [ADDR_W-1:0]               redirect_pc_o,
    output logic                            wdog_o,
    output logic [$clog2(WDOG_LIMIT+1)-1:0] stall_cnt_o
`ifdef PIPE_STALL_PERF_EN
    ,
    input  logic [$clog2(STAGES)-1:0]       perf_sel_i,
    output logic [31:0]                     perf_cnt_o
`endif
);

    import pipe_ctrl_pkg::*;

    localparam logic [FLUSH_CNT_W-1:0] FL_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [STAGES-1:0] REQ_MASK  = {{(STAGES-1){1'b1}}, 1'b0};
    localparam logic [STAGES-1:0] KEEP_MASK = {1'b1, {(STAGES-2){1'b0}}, 1'b1};

    logic [STAGES-1:0]      req_eff;
    logic [STAGES-1:0]      req_scan;
    logic                   scan_acc;
    flush_state_t           state, state_n;
    logic [FLUSH_CNT_W-1:0] fl_cnt, fl_cnt_n;

    // The PC stage cannot request a stall itself
    assign req_eff = stall_req_i & REQ_MASK;

    // Freeze every stage at or upstream of the deepest requester
    always_comb begin
        scan_acc = 1'b0;
        req_scan = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            scan_acc    = scan_acc | req_eff[j];
            req_scan[j] = scan_acc;
        end
    end

    // Flushed bubbles must drain, so middle stages ignore stalls during a flush
    assign stall_o = flush_o ? (req_scan & KEEP_MASK) : req_scan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FL_IDLE;
            fl_cnt <= '0;
        end else begin
            state  <= state_n;
            fl_cnt <= fl_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        fl_cnt_n = fl_cnt;
        flush_o  = 1'b0;
        case (state)
            FL_IDLE: begin
                if (except_flush_i) begin
                    flush_o  = 1'b1;
                    fl_cnt_n = FL_RELOAD;
                    state_n  = (FL_RELOAD != '0) ? FL_FLUSH : FL_IDLE;
                end
            end
            FL_FLUSH: begin
                flush_o = 1'b1;
                if (except_flush_i) begin
                    fl_cnt_n = FL_RELOAD;
                end else begin
                    fl_cnt_n = fl_cnt - 1'b1;
                end
                state_n = (fl_cnt_n != '0) ? FL_FLUSH : FL_IDLE;
            end
            default: begin
                state_n  = FL_IDLE;
                fl_cnt_n = '0;
            end
        endcase
    end

    // Newest exception always wins over a simultaneous hand-off to fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else if (except_flush_i) begin
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= except_pc_i;
        end else if (redirect_valid_o && redirect_ready_i && !stall_o[STG_PC]) begin
            redirect_valid_o <= 1'b0;
        end
    end

    stall_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall_o[STG_PC]),
        .flush     (flush_o),
        .clr       (wdog_clr_i),
        .stall_cnt (stall_cnt_o),
        .wdog      (wdog_o)
    );

`ifdef PIPE_STALL_PERF_EN
    localparam int SEL_W = $clog2(STAGES);

    logic [31:0]      perf_cnt [STAGES];
    logic [SEL_W-1:0] deep_idx;

    always_comb begin
        deep_idx = '0;
        for (int k = 1; k < STAGES; k++) begin
            if (req_eff[k]) begin
                deep_idx = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                perf_cnt[k] <= '0;
            end
        end else if (|req_eff) begin
            perf_cnt[deep_idx] <= perf_cnt[deep_idx] + 32'd1;
        end
    end

    assign perf_cnt_o = (int'(perf_sel_i) < STAGES) ? perf_cnt[perf_sel_i] : 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    import pipe_ctrl_pkg::*;

    localparam int STAGES = 6;
    localparam int FLUSH_CYCLES = 3;
    localparam int WDOG_LIMIT = 8;
    localparam int ADDR_W = 32;
    localparam int CNT_W = $clog2(WDOG_LIMIT+1);

    logic              clk;
    logic              rst;
    logic [STAGES-1:0] stall_req_i;
    logic              except_flush_i;
    logic [ADDR_W-1:0] except_pc_i;
    logic              redirect_ready_i;
    logic              wdog_clr_i;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic              redirect_valid_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              wdog_o;
    logic [CNT_W-1:0]  stall_cnt_o;
`ifdef PIPE_STALL_PERF_EN
    logic [$clog2(STAGES)-1:0] perf_sel_i;
    logic [31:0]               perf_cnt_o;
`endif

    int n_checks = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(
        .STAGES       (STAGES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .WDOG_LIMIT   (WDOG_LIMIT),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_i      (stall_req_i),
        .except_flush_i   (except_flush_i),
        .except_pc_i      (except_pc_i),
        .redirect_ready_i (redirect_ready_i),
        .wdog_clr_i       (wdog_clr_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .wdog_o           (wdog_o),
        .stall_cnt_o      (stall_cnt_o)
`ifdef PIPE_STALL_PERF_EN
        ,
        .perf_sel_i       (perf_sel_i),
        .perf_cnt_o       (perf_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 64'(stall_o), 64'h0);
        check({tag, "_flush"}, 64'(flush_o), 64'h0);
        check({tag, "_rvalid"}, 64'(redirect_valid_o), 64'h0);
        check({tag, "_rpc"}, 64'(redirect_pc_o), 64'h0);
        check({tag, "_wdog"}, 64'(wdog_o), 64'h0);
        check({tag, "_scnt"}, 64'(stall_cnt_o), 64'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stall_vec_t exp_stall;

        rst = 1'b1;
        stall_req_i = '0;
        except_flush_i = 1'b0;
        except_pc_i = '0;
        redirect_ready_i = 1'b0;
        wdog_clr_i = 1'b0;
`ifdef PIPE_STALL_PERF_EN
        perf_sel_i = '0;
`endif
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Deepest-requester stall vectors (combinational, no clock edge between)
        stall_req_i = 6'b001010; #1;
        exp_stall = 6'b001111;
        check("stall_req_3_1", 64'(stall_o), 64'(exp_stall));
        stall_req_i = 6'b100000; #1;
        exp_stall = 6'b111111;
        check("stall_req_wb", 64'(stall_o), 64'(exp_stall));
        stall_req_i = 6'b000001; #1;
        check("stall_req_pc_ignored", 64'(stall_o), 64'h0);
        stall_req_i = 6'b000000; #1;
        check("stall_req_none", 64'(stall_o), 64'h0);

        // Single flush: three cycles of flush_o, redirect latched
        @(negedge clk);
        except_flush_i = 1'b1;
        except_pc_i = 32'hBFC00380;
        #1;
        check("fl1_c0_flush", 64'(flush_o), 64'h1);
        check("fl1_c0_rvalid", 64'(redirect_valid_o), 64'h0);
        @(negedge clk);
        except_flush_i = 1'b0;
        except_pc_i = 32'hDEADBEEF;
        #1;
        check("fl1_c1_flush", 64'(flush_o), 64'h1);
        check("fl1_c1_rvalid", 64'(redirect_valid_o), 64'h1);
        check("fl1_c1_rpc", 64'(redirect_pc_o), 64'hBFC00380);
        @(negedge clk);
        stall_req_i = 6'b010100;
        #1;
        check("fl1_c2_flush", 64'(flush_o), 64'h1);
        check("fl1_c2_stall_masked", 64'(stall_o), 64'b000001);
        stall_req_i = 6'b100000;
        #1;
        check("fl1_c2_stall_wb", 64'(stall_o), 64'b100001);
        @(negedge clk);
        stall_req_i = 6'b000000;
        #1;
        check("fl1_c3_flush", 64'(flush_o), 64'h0);
        check("fl1_c3_stall", 64'(stall_o), 64'h0);

        // Redirect held while fetch is not ready, then while PC is stalled
        redirect_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_not_ready", 64'(redirect_valid_o), 64'h1);
            check("hold_pc_stable", 64'(redirect_pc_o), 64'hBFC00380);
        end
        redirect_ready_i = 1'b1;
        stall_req_i = 6'b000010;
        @(negedge clk);
        check("hold_pc_stalled", 64'(redirect_valid_o), 64'h1);
        stall_req_i = 6'b000000;
        @(negedge clk);
        check("redirect_cleared", 64'(redirect_valid_o), 64'h0);
        redirect_ready_i = 1'b0;

        // Second flush one cycle into the first extends flush to four cycles
        @(negedge clk);
        except_flush_i = 1'b1;
        except_pc_i = 32'h11110000;
        #1;
        check("fl2_c0_flush", 64'(flush_o), 64'h1);
        @(negedge clk);
        except_pc_i = 32'h80000180;
        #1;
        check("fl2_c1_flush", 64'(flush_o), 64'h1);
        check("fl2_c1_rpc_first", 64'(redirect_pc_o), 64'h11110000);
        @(negedge clk);
        except_flush_i = 1'b0;
        #1;
        check("fl2_c2_flush", 64'(flush_o), 64'h1);
        check("fl2_c2_rvalid", 64'(redirect_valid_o), 64'h1);
        check("fl2_c2_rpc", 64'(redirect_pc_o), 64'h80000180);
        @(negedge clk);
        #1;
        check("fl2_c3_flush", 64'(flush_o), 64'h1);
        @(negedge clk);
        #1;
        check("fl2_c4_flush", 64'(flush_o), 64'h0);
        redirect_ready_i = 1'b1;
        @(negedge clk);
        check("fl2_redirect_cleared", 64'(redirect_valid_o), 64'h0);
        redirect_ready_i = 1'b0;

        // Watchdog: stage 2 stalls for ten cycles with a limit of eight
        stall_req_i = 6'b000100;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("wd_cnt", 64'(stall_cnt_o), 64'((i < WDOG_LIMIT) ? i : WDOG_LIMIT));
            check("wd_flag", 64'(wdog_o), 64'((i >= WDOG_LIMIT) ? 1 : 0));
        end
        stall_req_i = 6'b000000;
        @(negedge clk);
        check("wd_cnt_cleared", 64'(stall_cnt_o), 64'h0);
        check("wd_flag_sticky", 64'(wdog_o), 64'h1);
        wdog_clr_i = 1'b1;
        @(negedge clk);
        wdog_clr_i = 1'b0;
        check("wd_flag_cleared", 64'(wdog_o), 64'h0);

        // Asynchronous reset in the middle of a flush with a redirect pending
        @(negedge clk);
        except_flush_i = 1'b1;
        except_pc_i = 32'hBFC00380;
        @(negedge clk);
        except_flush_i = 1'b0;
        #1;
        check("rst_pre_flush", 64'(flush_o), 64'h1);
        check("rst_pre_rvalid", 64'(redirect_valid_o), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_flush", 64'(flush_o), 64'h0);
            check("post_rst_rvalid", 64'(redirect_valid_o), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
